// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game sequencer and its surroundings:
// button and frame inputs toward the sequencer, and status and enables back out.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic       miss_l;
    logic       miss_r;
    logic [2:0] state;
    logic       paddle_en;
    logic       ball_en;
    logic       ball_hold;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic       game_over;

    // Environment side: drives buttons/frame pulses, observes sequencer status.
    modport master (
        output frame_tick, start, pause, miss_l, miss_r,
        input  state, paddle_en, ball_en, ball_hold, serve_dir,
        input  score_l, score_r, winner, game_over
    );

    // Sequencer side.
    modport slave (
        input  frame_tick, start, pause, miss_l, miss_r,
        output state, paddle_en, ball_en, ball_hold, serve_dir,
        output score_l, score_r, winner, game_over
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: owns the game FSM, scores and frame-counted pauses,
// and gates the paddle/ball datapaths through Moore enable/hold outputs.
module pong_game_ctrl #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state_q, state_n;
    logic       start_q, pause_q;
    logic       start_ev, pause_ev;
    logic [7:0] fcnt_q, fcnt_n;
    logic [3:0] score_l_q, score_l_n;
    logic [3:0] score_r_q, score_r_n;
    logic [1:0] winner_q, winner_n;
    logic       serve_dir_q, serve_dir_n;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Button history resets high so a button held through reset is not an event.
    assign start_ev = bus.start & ~start_q;
    assign pause_ev = bus.pause & ~pause_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b1;
            pause_q     <= 1'b1;
            fcnt_q      <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            winner_q    <= '0;
            serve_dir_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            start_q     <= bus.start;
            pause_q     <= bus.pause;
            fcnt_q      <= fcnt_n;
            score_l_q   <= score_l_n;
            score_r_q   <= score_r_n;
            winner_q    <= winner_n;
            serve_dir_q <= serve_dir_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        score_l_n   = score_l_q;
        score_r_n   = score_r_q;
        winner_n    = winner_q;
        serve_dir_n = serve_dir_q;

        case (state_q)
            IDLE, OVER: begin
                if (start_ev) begin
                    state_n     = SERVE;
                    score_l_n   = '0;
                    score_r_n   = '0;
                    winner_n    = '0;
                    serve_dir_n = 1'b0;
                end
            end
            SERVE: begin
                if (bus.frame_tick && (fcnt_q == SERVE_LAST)) begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                // A miss outranks a pause event on the same cycle.
                if (bus.miss_l || bus.miss_r) begin
                    state_n = POINT;
                    if (bus.miss_l && !bus.miss_r) begin
                        score_r_n   = sat_inc(score_r_q);
                        serve_dir_n = 1'b0;
                    end else if (bus.miss_r && !bus.miss_l) begin
                        score_l_n   = sat_inc(score_l_q);
                        serve_dir_n = 1'b1;
                    end
                end else if (pause_ev) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_ev) begin
                    state_n = PLAY;
                end
            end
            POINT: begin
                if (bus.frame_tick && (fcnt_q == POINT_LAST)) begin
                    if (score_l_q == WIN) begin
                        winner_n = 2'b01;
                        state_n  = OVER;
                    end else if (score_r_q == WIN) begin
                        winner_n = 2'b10;
                        state_n  = OVER;
                    end else begin
                        state_n = SERVE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Any state change, including recovery from an illegal code, restarts the frame count.
    always_comb begin
        fcnt_n = fcnt_q;
        if (state_n != state_q) begin
            fcnt_n = '0;
        end else if (bus.frame_tick && ((state_q == SERVE) || (state_q == POINT))) begin
            fcnt_n = fcnt_q + 8'd1;
        end
    end

    always_comb begin
        bus.paddle_en = 1'b0;
        bus.ball_en   = 1'b0;
        bus.ball_hold = 1'b0;
        bus.game_over = 1'b0;
        case (state_q)
            IDLE:  bus.ball_hold = 1'b1;
            SERVE: begin
                bus.paddle_en = 1'b1;
                bus.ball_hold = 1'b1;
            end
            PLAY: begin
                bus.paddle_en = 1'b1;
                bus.ball_en   = 1'b1;
            end
            POINT: bus.ball_hold = 1'b1;
            OVER: begin
                bus.ball_hold = 1'b1;
                bus.game_over = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
    assign bus.winner    = winner_q;
    assign bus.serve_dir = serve_dir_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for the Pong design. It owns the match state machine and gates the two paddle controllers and the ball mover through enable and hold outputs. It keeps both scores and inserts frame-counted serve and point pauses. All timing is counted in VGA frames via a one-cycle `frame_tick` from the display timing logic. Sits between the debounced button inputs, the paddle/ball datapaths and the score display.

## Interface
Parameters:
- `SERVE_FRAMES`, 60, frames spent in SERVE before the ball launches (1..255)
- `POINT_FRAMES`, 30, frames the point-scored pause lasts (1..255)
- `WIN_SCORE`, 7, score that ends the match (1..15)

Ports:
- `clk`  in  1  system clock; all logic on posedge
- `reset`  in  1  synchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per frame
- `start`  in  1  debounced start button, level
- `pause`  in  1  debounced pause button, level
- `miss_l`  in  1  one-cycle pulse: ball passed the left paddle
- `miss_r`  in  1  one-cycle pulse: ball passed the right paddle
- `state`  out  3  current state code
- `paddle_en`  out  1  enable to both paddle counters
- `ball_en`  out  1  ball movement enable
- `ball_hold`  out  1  holds the ball at centre
- `serve_dir`  out  1  launch direction: 0 = left, 1 = right
- `score_l`  out  4  left player score
- `score_r`  out  4  right player score
- `winner`  out  2  00 none, 01 left, 10 right
- `game_over`  out  1  match finished

## Operation
- State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5. Codes 6 and 7 are illegal and recover to IDLE on the next edge.
- Edge detect on `start` and `pause`:
  - Registers `start_q` and `pause_q` reset to 1, so a button held through reset produces no event.
  - An event is `in & ~in_q`.
- Frame counter `fcnt` is 8 bits. It clears on every state entry and increments on `frame_tick` in SERVE and POINT only.
- Moore outputs, decoded from the state register:
  - `paddle_en`=1 in SERVE and PLAY.
  - `ball_en`=1 in PLAY only.
  - `ball_hold`=1 in IDLE, SERVE, POINT and OVER.
  - `game_over`=1 in OVER.
- IDLE: a start event goes to SERVE and clears scores, `winner` and `serve_dir`.
- SERVE: when `frame_tick` arrives with `fcnt == SERVE_FRAMES-1`, go to PLAY.
- PLAY:
  - `miss_l` only: `score_r`+1, `serve_dir`<=0, go to POINT.
  - `miss_r` only: `score_l`+1, `serve_dir`<=1, go to POINT.
  - Both in the same cycle: no score change, `serve_dir` unchanged, go to POINT.
  - Pause event (with no miss in the same cycle): go to PAUSE. A miss in the same cycle takes priority over pause.
- PAUSE:
  - Misses are ignored.
  - `fcnt` is frozen.
  - A pause event returns to PLAY.
- POINT: when `frame_tick` arrives with `fcnt == POINT_FRAMES-1`:
  - If `score_l == WIN_SCORE`, set `winner`=01 and go to OVER.
  - Else if `score_r == WIN_SCORE`, set `winner`=10 and go to OVER.
  - Else go to SERVE.
- OVER: a start event goes to SERVE, clearing scores, `winner` and `serve_dir`.
- Start events in SERVE, PLAY, POINT and PAUSE are ignored. Pause events outside PLAY and PAUSE are ignored.
- Scores saturate at 15. They never wrap.

## Timing
- Reset: sampled on a posedge with `reset`=0, regardless of state. After that edge:
  - `state`=IDLE, scores=0, `winner`=00, `serve_dir`=0, `fcnt`=0.
  - `paddle_en`=0, `ball_en`=0, `ball_hold`=1, `game_over`=0.
- Latency: one clock. An input sampled at edge N changes `state` and all outputs after edge N, since they are decoded from registers with no comb path from inputs.
- Start/pause event latency: the button must be low at edge N-1 and high at edge N. The state changes after edge N.
- A frame_tick in the same cycle as a state entry is not counted; `fcnt` clears instead.
- SERVE lasts exactly `SERVE_FRAMES` frame_ticks. POINT lasts exactly `POINT_FRAMES` frame_ticks.
- Score registers update on the same edge as the PLAY→POINT transition.

## Test plan
Bench parameters: `SERVE_FRAMES`=2, `POINT_FRAMES`=2, `WIN_SCORE`=3, `frame_tick` every 8 cycles.

- Reset and idle: `reset`=0 for 2 edges with `start` held high, then release, keep `start` high → state=0, `ball_hold`=1, `paddle_en`=0, no SERVE entry until `start` is dropped and raised again.
- Serve launch: start event → state=1 with `paddle_en`=1. After the 2nd `frame_tick`, state=2 with `ball_en`=1 and `ball_hold`=0.
- Point scoring: in PLAY pulse `miss_l` → next cycle state=3, `score_r`=1, `serve_dir`=0. After 2 ticks state=1.
- Simultaneous misses: `miss_l`=`miss_r`=1 in one cycle → state=3, scores unchanged, `serve_dir` unchanged.
- Pause: pause event in PLAY → state=4, `ball_en`=0, `paddle_en`=0. A `miss_r` in PAUSE is ignored. A second pause event → state=2.
- Win and restart: drive three `miss_r` points → after the 3rd POINT, state=5, `winner`=01, `game_over`=1. A start event → state=1 with scores 0 and `winner`=00. Also assert `reset` mid-POINT → IDLE after one edge.
